// File: rtl/pmod_led_pattern_pkg.sv
// Shared definitions for the pmod LED pattern generator: pattern mode codes
// and parameter limits.
package pmod_led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_ROT    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam int LED_W_MIN = 2;
    localparam int LED_W_MAX = 32;

endpackage

// File: rtl/pmod_led_pattern_tick_gen.sv
// Prescaler counting 0..DIV-1 while enabled, with a pulse on the wrap cycle.
// Reusable by other pmod examples.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_gen: DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          at_top;

    assign at_top = (cnt == CW'(DIV - 1));
    // High on the edge where the count wraps, so a registered consumer sees it one step late-free.
    assign tick   = en && at_top;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_top ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pmod_led_pattern.sv
// LED pattern generator for the 2x8 LED pmod: binary, Gray, rotate and bounce
// patterns stepped by a prescaler tick or a manual step, with optional heartbeat.
module pmod_led_pattern
    import pmod_led_pattern_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int TICK_HZ   = 1,
    parameter int LED_W     = 16,
    parameter int HEARTBEAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    output logic [LED_W-1:0] led,
    output logic             tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = LED_W - HEARTBEAT;

    generate
        if (LED_W < LED_W_MIN || LED_W > LED_W_MAX) begin : g_bad_led_w
            $error("pmod_led_pattern: LED_W must be in 2..32");
        end
        if (HEARTBEAT != 0 && HEARTBEAT != 1) begin : g_bad_hb
            $error("pmod_led_pattern: HEARTBEAT must be 0 or 1");
        end
    endgenerate

    mode_t          mode_in;
    mode_t          mode_q;
    logic           mode_chg;
    logic           wrap;
    logic           advance;
    logic [PW-1:0]  bin;
    logic [PW-1:0]  bin_nxt;
    logic [PW-1:0]  onehot;
    logic [PW-1:0]  onehot_nxt;
    logic           bdir;
    logic           bdir_nxt;
    logic           hb;
    logic [PW-1:0]  pat;

    assign mode_in  = mode_t'(mode);
    assign mode_chg = (mode_in != mode_q);
    assign advance  = wrap || (!run && step);
    assign bin_nxt  = dir ? bin - PW'(1) : bin + PW'(1);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (mode_chg),
        .tick (wrap)
    );

    // bdir: 0 = moving toward MSB, 1 = moving toward LSB; it flips on the step that lands on an end.
    always_comb begin
        onehot_nxt = onehot;
        bdir_nxt   = bdir;
        if (mode_q == MODE_ROT) begin
            onehot_nxt = dir ? ((onehot >> 1) | (onehot << (PW - 1)))
                             : ((onehot << 1) | (onehot >> (PW - 1)));
        end else if (mode_q == MODE_BOUNCE && PW > 1) begin
            if (!bdir) begin
                onehot_nxt = onehot << 1;
                if (onehot_nxt[PW-1]) bdir_nxt = 1'b1;
            end else begin
                onehot_nxt = onehot >> 1;
                if (onehot_nxt[0]) bdir_nxt = 1'b0;
            end
        end
    end

    // A mode change reseeds the pattern and swallows any coincident step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_BIN;
            bin    <= '0;
            onehot <= PW'(1);
            bdir   <= 1'b0;
            hb     <= 1'b0;
            tick   <= 1'b0;
        end else if (mode_chg) begin
            mode_q <= mode_in;
            bin    <= '0;
            onehot <= PW'(1);
            bdir   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= advance;
            if (advance) begin
                bin    <= bin_nxt;
                onehot <= onehot_nxt;
                bdir   <= bdir_nxt;
                hb     <= ~hb;
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_BIN:  pat = bin;
            MODE_GRAY: pat = bin ^ (bin >> 1);
            default:   pat = onehot;
        endcase
    end

    generate
        if (HEARTBEAT != 0) begin : g_hb
            assign led = {pat, hb};
        end else begin : g_no_hb
            assign led = pat;
        end
    endgenerate

endmodule

// File: tb/tb_pmod_led_pattern.sv
// Directed bench for pmod_led_pattern with DIV=8, LED_W=16, heartbeat on led[0].
module tb_pmod_led_pattern;
    import pmod_led_pattern_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] led;
    logic        tick;

    int n_cmp  = 0;
    int n_fail = 0;

    pmod_led_pattern #(
        .CLK_HZ    (8),
        .TICK_HZ   (1),
        .LED_W     (16),
        .HEARTBEAT (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .run  (run),
        .step (step),
        .dir  (dir),
        .led  (led),
        .tick (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset with the target mode already presented, then one edge for the mode to load.
    task automatic reset_into(input logic [1:0] m, input logic d);
        mode = m;
        dir  = d;
        run  = 1'b0;
        step = 1'b0;
        rst  = 1'b1;
        cycle();
        rst  = 1'b0;
        cycle();
    endtask

    task automatic adv(input int n, input string name);
        int seen = 0;
        int budget = n * 8 + 20;
        run = 1'b1;
        while (seen < n && budget > 0) begin
            cycle();
            if (tick) seen++;
            budget--;
        end
        n_cmp++;
        if (seen !== n) begin
            n_fail++;
            $display("FAIL %s_ticks: got %0d ticks, want %0d", name, seen, n);
        end
    endtask

    task automatic cycles_to_tick(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        mode = 2'd2;
        run  = 1'b1;
        rst  = 1'b1;
        cycle();
        n_cmp++;
        if (led !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_led: got %h, want 0000", led);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b, want 0", tick);
        end
        run = 1'b0;
        rst = 1'b0;
        cycle();
        n_cmp++;
        if (led !== 16'h0002) begin
            n_fail++;
            $display("FAIL reset_rot_seed: got %h, want 0002", led);
        end
    endtask

    task automatic test_bin_free_run();
        logic [15:0] exp_tab [5] = '{16'h0003, 16'h0004, 16'h0007, 16'h0008, 16'h000B};
        int idx = 0;
        reset_into(2'd0, 1'b0);
        run = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            n_cmp++;
            if (tick !== ((k % 8) == 0)) begin
                n_fail++;
                $display("FAIL bin_tick_cycle%0d: got %b, want %b", k, tick, (k % 8) == 0);
            end
            if (tick && idx < 5) begin
                n_cmp++;
                if (led !== exp_tab[idx]) begin
                    n_fail++;
                    $display("FAIL bin_led_step%0d: got %h, want %h", idx + 1, led, exp_tab[idx]);
                end
                idx++;
            end
        end
    endtask

    task automatic test_bin_down_gray();
        reset_into(2'd0, 1'b1);
        adv(1, "bin_down");
        n_cmp++;
        if (led !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bin_down_wrap: got %h, want ffff", led);
        end
        reset_into(2'd1, 1'b0);
        adv(3, "gray");
        n_cmp++;
        if (led !== 16'h0005) begin
            n_fail++;
            $display("FAIL gray_3: got %h, want 0005", led);
        end
    endtask

    task automatic test_rot();
        reset_into(2'd2, 1'b0);
        adv(1, "rot_up1");
        n_cmp++;
        if (led !== 16'h0005) begin
            n_fail++;
            $display("FAIL rot_up1: got %h, want 0005", led);
        end
        adv(14, "rot_up15");
        n_cmp++;
        if (led !== 16'h0003) begin
            n_fail++;
            $display("FAIL rot_wrap: got %h, want 0003", led);
        end
        reset_into(2'd2, 1'b1);
        adv(1, "rot_down");
        n_cmp++;
        if (led !== 16'h8001) begin
            n_fail++;
            $display("FAIL rot_down_wrap: got %h, want 8001", led);
        end
    endtask

    task automatic test_bounce();
        reset_into(2'd3, 1'b1);
        adv(14, "bounce14");
        n_cmp++;
        if (led !== 16'h8000) begin
            n_fail++;
            $display("FAIL bounce_top: got %h, want 8000", led);
        end
        adv(1, "bounce15");
        n_cmp++;
        if (led !== 16'h4001) begin
            n_fail++;
            $display("FAIL bounce_back1: got %h, want 4001", led);
        end
        adv(1, "bounce16");
        n_cmp++;
        if (led !== 16'h2000) begin
            n_fail++;
            $display("FAIL bounce_back2: got %h, want 2000", led);
        end
        adv(12, "bounce28");
        n_cmp++;
        if (led !== 16'h0002) begin
            n_fail++;
            $display("FAIL bounce_bottom: got %h, want 0002", led);
        end
        adv(1, "bounce29");
        n_cmp++;
        if (led !== 16'h0005) begin
            n_fail++;
            $display("FAIL bounce_up_again: got %h, want 0005", led);
        end
    endtask

    task automatic test_step_hold();
        int n;
        int ticks;
        reset_into(2'd0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            step = (k == 3 || k == 10);
            cycle();
            step = 1'b0;
            n_cmp++;
            if (tick !== (k == 3 || k == 10)) begin
                n_fail++;
                $display("FAIL step_tick_cycle%0d: got %b, want %b", k, tick, (k == 3 || k == 10));
            end
        end
        n_cmp++;
        if (led !== 16'h0004) begin
            n_fail++;
            $display("FAIL step_led: got %h, want 0004", led);
        end
        run = 1'b1;
        cycles_to_tick(n);
        n_cmp++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL step_cnt_frozen: got %0d cycles, want 8", n);
        end
        // step while running must not add an advance
        reset_into(2'd0, 1'b0);
        run = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 8; k++) begin
            step = (k == 2);
            cycle();
            step = 1'b0;
            if (tick) ticks++;
        end
        n_cmp++;
        if (ticks !== 1 || led !== 16'h0003) begin
            n_fail++;
            $display("FAIL step_while_run: got %0d ticks led %h, want 1 ticks led 0003", ticks, led);
        end
        // pause mid-count and resume
        reset_into(2'd0, 1'b0);
        run = 1'b1;
        repeat (5) cycle();
        run = 1'b0;
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (tick) ticks++;
        end
        run = 1'b1;
        cycles_to_tick(n);
        n_cmp++;
        if (ticks !== 0 || n !== 3) begin
            n_fail++;
            $display("FAIL pause_resume: got %0d held ticks, %0d cycles, want 0 and 3", ticks, n);
        end
    endtask

    task automatic test_mode_change();
        int n;
        reset_into(2'd0, 1'b0);
        run = 1'b1;
        repeat (7) cycle();
        mode = 2'd2;
        cycle();
        n_cmp++;
        if (tick !== 1'b0 || led !== 16'h0002) begin
            n_fail++;
            $display("FAIL mode_chg_override: got tick %b led %h, want tick 0 led 0002", tick, led);
        end
        cycles_to_tick(n);
        n_cmp++;
        if (n !== 8 || led !== 16'h0005) begin
            n_fail++;
            $display("FAIL mode_chg_next: got %0d cycles led %h, want 8 cycles led 0005", n, led);
        end
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        n_cmp++;
        if (led !== 16'h0000 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got led %h tick %b, want 0000 0", led, tick);
        end
        rst = 1'b0;
        run = 1'b0;
        cycle();
        n_cmp++;
        if (led !== 16'h0002) begin
            n_fail++;
            $display("FAIL rst_mid_reseed: got %h, want 0002", led);
        end
    endtask

    initial begin
        repeat (2) cycle();
        test_reset();
        test_bin_free_run();
        test_bin_down_gray();
        test_rot();
        test_bounce();
        test_step_hold();
        test_mode_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
